param_down_counter: RTL and testbench

//  Parametrised, loadable down counter; successor to the fixed 4-bit free-running down counter.

---
 rtl/param_down_counter.sv | 167 ++++++++++++++++
 tb/tb_param_down_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/param_down_counter.sv
// -----------------------------------------------------------------------------
// param_down_counter
//
// Loadable, prescaled down counter for timers and event sequencing.
// The counter starts at a programmable reload value and counts down to 0.
// A count step ("tick") happens once every PRESCALE enabled cycles.
// At 0 the counter either reloads (auto-reload) or halts (one-shot).
// The terminal-count pulse tc is high for one cycle after the zero tick.
// done stays high while the one-shot counter is halted.
// Every output comes from a register, so no combinational path runs from an
// input to an output.
//
// Parameters
//   WIDTH     counter / reload width in bits (>= 1)
//   PRESCALE  enabled cycles per count tick (>= 1); 1 = tick on every enabled cycle
//   RST_VAL   value loaded into count and the reload register by rst
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high (highest priority)
//   en        in   1      count enable; low freezes count, prescaler and state
//   load      in   1      load strobe: count and reload register take load_val
//   load_val  in   WIDTH  value captured on load
//   mode      in   1      0 = auto-reload at 0, 1 = one-shot (halt at 0)
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse, one cycle wide
//   done      out  1      one-shot complete; high while halted
// -----------------------------------------------------------------------------
module param_down_counter #(
    parameter int               WIDTH    = 4,
    parameter int               PRESCALE = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    // The prescaler needs at least one bit, even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Last prescaler phase. When PRESCALE is 1 this is 0, and the prescaler
    // stays at 0, so every enabled cycle is a tick.
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Architectural state
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_r;
    logic [PW-1:0]    presc_r;
    logic [0:0]       state_r;
    logic             tc_r;
    logic             done_r;

    // Next-state values
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] reload_nxt_s;
    logic [PW-1:0]    presc_nxt_s;
    logic [0:0]       state_nxt_s;
    logic             tc_nxt_s;
    logic             done_nxt_s;

    logic             tick_s;
    logic             count_zero_s;

    // Tick qualification: an enabled cycle in the last prescaler phase.
    always_comb begin
        tick_s       = en & (presc_r == PRESC_LAST);
        count_zero_s = (count_r == {WIDTH{1'b0}});
    end

    // Next-state logic. load overrides the counting behaviour (and en).
    // tc defaults to 0, so it is a pulse that lasts exactly one cycle.
    always_comb begin
        count_nxt_s  = count_r;
        reload_nxt_s = reload_r;
        presc_nxt_s  = presc_r;
        state_nxt_s  = state_r;
        tc_nxt_s     = 1'b0;
        done_nxt_s   = done_r;

        if (load) begin
            count_nxt_s  = load_val;
            reload_nxt_s = load_val;
            presc_nxt_s  = {PW{1'b0}};
            state_nxt_s  = ST_RUN;
            done_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!en) begin
                        // Disabled: every register keeps its value.
                        count_nxt_s = count_r;
                    end else if (!tick_s) begin
                        presc_nxt_s = presc_r + PW'(1);
                    end else begin
                        presc_nxt_s = {PW{1'b0}};
                        if (!count_zero_s) begin
                            count_nxt_s = count_r - WIDTH'(1);
                        end else if (!mode) begin
                            // Auto-reload. mode matters only here, at the zero tick.
                            count_nxt_s = reload_r;
                            tc_nxt_s    = 1'b1;
                        end else begin
                            // One-shot complete: hold 0 until load or rst.
                            count_nxt_s = {WIDTH{1'b0}};
                            tc_nxt_s    = 1'b1;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    // Halted: ticks are ignored. Only load (above) or rst (below)
                    // leaves this state.
                    count_nxt_s = {WIDTH{1'b0}};
                    presc_nxt_s = {PW{1'b0}};
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    // An unreachable encoding recovers to a safe, reset-like state.
                    count_nxt_s  = RST_VAL;
                    reload_nxt_s = RST_VAL;
                    presc_nxt_s  = {PW{1'b0}};
                    state_nxt_s  = ST_RUN;
                    done_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State registers. Synchronous reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= RST_VAL;
            reload_r <= RST_VAL;
            presc_r  <= {PW{1'b0}};
            state_r  <= ST_RUN;
            tc_r     <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            reload_r <= reload_nxt_s;
            presc_r  <= presc_nxt_s;
            state_r  <= state_nxt_s;
            tc_r     <= tc_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // The outputs come straight from registers.
    always_comb begin
        count = count_r;
        tc    = tc_r;
        done  = done_r;
    end

endmodule

// File: tb/tb_param_down_counter.sv
// -----------------------------------------------------------------------------
// tb_param_down_counter
//
// Drives two instances with the same input stream:
//   u_p1  WIDTH=4, PRESCALE=1
//   u_p3  WIDTH=4, PRESCALE=3
// It first runs directed steps, then randomized steps.
//
// The reference model does not track a prescaler or a state machine. It counts
// the enabled cycles (n) since the current period started. From the period
// rules it derives:
//   count = reload - n / P
//   zero tick when n reaches (reload + 1) * P
// -----------------------------------------------------------------------------
module tb_param_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       mode;

    logic [3:0] count_p1;
    logic       tc_p1;
    logic       done_p1;
    logic [3:0] count_p3;
    logic       tc_p3;
    logic       done_p3;

    int n_checks;
    int n_fail;

    // Reference model, one slot per instance
    int pre   [2];
    int m_n   [2];
    int m_rl  [2];
    int m_halt[2];
    int m_tc  [2];
    int m_done[2];

    param_down_counter #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .count(count_p1), .tc(tc_p1), .done(done_p1)
    );

    param_down_counter #(.WIDTH(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .count(count_p3), .tc(tc_p3), .done(done_p3)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected count for instance i, as defined by the model
    function automatic int exp_count(input int i);
        if (m_halt[i] != 0) begin
            return 0;
        end else begin
            return (m_rl[i] - m_n[i] / pre[i]) & 15;
        end
    endfunction

    // Advance the model by one clock edge, using the inputs applied to that edge
    task automatic model_edge(input int i);
        if (rst) begin
            m_rl[i] = 15; m_n[i] = 0; m_halt[i] = 0; m_tc[i] = 0; m_done[i] = 0;
        end else if (load) begin
            m_rl[i] = int'(load_val); m_n[i] = 0; m_halt[i] = 0; m_tc[i] = 0; m_done[i] = 0;
        end else begin
            m_tc[i] = 0;
            if (en && m_halt[i] == 0) begin
                m_n[i] = m_n[i] + 1;
                if (m_n[i] == (m_rl[i] + 1) * pre[i]) begin
                    m_tc[i] = 1;
                    if (mode) begin
                        m_halt[i] = 1;
                        m_done[i] = 1;
                    end else begin
                        m_n[i] = 0;
                    end
                end
            end
        end
    endtask

    // One comparison: counts it, and counts and reports it if it fails
    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then compare both instances
    task automatic step(input logic r, input logic ld, input logic [3:0] lv,
                        input logic md, input logic e, input string tag);
        rst = r; load = ld; load_val = lv; mode = md; en = e;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk({tag, "/p1.count"}, int'(count_p1), exp_count(0));
        chk({tag, "/p1.tc"},    int'(tc_p1),    m_tc[0]);
        chk({tag, "/p1.done"},  int'(done_p1),  m_done[0]);
        chk({tag, "/p3.count"}, int'(count_p3), exp_count(1));
        chk({tag, "/p3.tc"},    int'(tc_p3),    m_tc[1]);
        chk({tag, "/p3.done"},  int'(done_p3),  m_done[1]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pre[0] = 1;
        pre[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_rl[i] = 15; m_halt[i] = 0; m_tc[i] = 0; m_done[i] = 0;
        end
        rst = 1'b1; load = 1'b0; load_val = 4'd0; mode = 1'b0; en = 1'b0;

        // T1: reset, then reset together with load
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "t1_rst");
        chk("t1_rst_const", int'(count_p1), 15);
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, "t1_rst_load");
        chk("t1_rst_load_const", int'(count_p3), 15);

        // T2: auto-reload wrap from 15. The 16th tick shows tc with count back at 15.
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t2_wrap");
        end
        chk("t2_wrap_count_const", int'(count_p1), 15);
        chk("t2_wrap_tc_const", int'(tc_p1), 1);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t2_second_period");
        end
        chk("t2_second_tc_const", int'(tc_p1), 1);

        // T3: one-shot from 5, halt, stay halted, then reload 3
        step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, "t3_load5");
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "t3_oneshot");
        end
        chk("t3_done_const", int'(done_p3), 1);
        chk("t3_halt_count_const", int'(count_p1), 0);
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, "t3_load3");
        chk("t3_reload_done_const", int'(done_p1), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "t3_resume");
        end

        // T4: prescale, with en dropped in the middle of a prescale period
        step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, "t4_load2");
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t4_run");
        end
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "t4_frozen");
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t4_resume");
        end

        // T5: load wins over a pending tick; rst wins over load
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t5_pre");
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, "t5_load9");
        chk("t5_load9_const", int'(count_p3), 9);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t5_after_load");
        end
        step(1'b1, 1'b1, 4'd9, 1'b0, 1'b1, "t5_rst_load");

        // T6: reload of 0 gives tc on every tick; mode flipped in the middle of a count
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, "t6_load0");
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t6_zero_reload");
        end
        step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, "t6_load4");
        for (int k = 1; k <= 2; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t6_auto");
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "t6_flip");
        end

        // Randomized stimulus
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
